segment_scan_ctrl: RTL and testbench
====================================

// Module: segment_scan_ctrl
// PURPOSE
//  Time-multiplexes one shared seven-segment driver across NUM_DIGITS common-anode digits.
//  - Round-robin scan. Each digit slot is a blanking interval followed by a dwell interval.
//  - A valid/ready load port double-buffers new display values; they are committed only at frame boundaries.
//  - Sits between the gesture/count logic (producer of nibbles) and the board display pins.
//  - Digit decode uses the existing seven_segment decoder.
// PARAMETERS
//  NUM_DIGITS    4    digits scanned per frame, >=2
//  DWELL_CYCLES  50000  clocks each digit is lit, >=1
//  BLANK_CYCLES  500  clocks all digits are off before each dwell (anti-ghosting), >=1
// PORTS
//  Clock         in   1             system clock; all logic on posedge
//  Reset         in   1             synchronous, active-high reset
//  load_valid    in   1             producer offers load_value
//  load_ready    out  1             block can accept a load
//  load_value    in   4*NUM_DIGITS  nibble k = digit k value
//  digit_enable  in   NUM_DIGITS    per-digit enable, sampled live
//  digit_sel     out  NUM_DIGITS    one-hot digit select, active-high; 0 = none lit
//  segments      out  7             {g,f,e,d,c,b,a}, active-low; 7'h7F = blank
//  frame_done    out  1             high for the last dwell cycle of digit NUM_DIGITS-1
// BEHAVIOUR
//  - Reset is synchronous and active-high. On the cycle after Reset is seen high:
//    - state=BLANK, idx=0, timer=0, display=0, shadow=0, pending=0.
//    - Outputs: digit_sel=0, segments=7'h7F, load_ready=1, frame_done=0.
//    - A load that is pending when Reset arrives is discarded.
//  - FSM states are BLANK and SHOW. All outputs are Moore outputs: no combinational path from any input to any output.
//    - BLANK: digit_sel=0 and segments=7'h7F.
//      - Stays exactly BLANK_CYCLES cycles, then moves to SHOW with the same idx.
//    - SHOW: digit_sel=onehot(idx) if digit_enable[idx], else 0. segments=seven_segment(display[idx]) if enabled, else 7'h7F.
//      - Stays exactly DWELL_CYCLES cycles, then moves to BLANK.
//      - idx increments, wrapping NUM_DIGITS-1 -> 0.
//  - Timer width is $clog2(max(DWELL_CYCLES,BLANK_CYCLES)). The timer clears on every state change.
//  - The frame period is fixed at NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES) and does not depend on digit_enable.
//  - Load handshake:
//    - A load is accepted when load_valid && load_ready. On acceptance, shadow<=load_value and pending<=1.
//    - load_ready = !pending.
//    - load_valid may drop without acceptance; nothing is latched.
//  - Frame boundary is the last SHOW cycle with idx=NUM_DIGITS-1, i.e. the cycle with frame_done=1.
//    - At the end of that cycle, if pending: display<=shadow and pending<=0.
//    - load_ready returns to 1 on the next cycle.
//  - A load accepted during the boundary cycle itself (pending was 0) stays pending until the next boundary.
//  - digit_enable changes take effect on the next cycle, even mid-dwell.
//  - Nibble k of display maps to digit_sel bit k.
// TESTING  (NUM_DIGITS=4, DWELL_CYCLES=4, BLANK_CYCLES=2, cycle 0 = first after Reset release)
//  1. Reset, idle load port:
//     - Cycles 0-1 blank. Digit0 lit cycles 2-5, digit1 8-11, digit2 14-17, digit3 20-23.
//     - Digit0 lit again from cycle 26; frame_done=1 only in cycle 23.
//     - Lit digits show segments for "0".
//  2. load_value=16'h1234 with load_valid=1 in cycle 5:
//     - load_ready=0 for cycles 6-23 and 1 in cycle 24.
//     - Frame 0 shows 0000. Digit0 shows "4" in cycles 26-29; digit3 shows "1" in cycles 44-47.
//  3. digit_enable=4'b1011:
//     - Cycles 14-17 give digit_sel=0 and segments=7'h7F.
//     - Digit3 is still lit at cycles 20-23; the frame stays 24 cycles.
//  4. load_valid held at 1 with load_value changing every cycle:
//     - Exactly one value is accepted per frame, the one present when load_ready=1.
//     - The accepted value is displayed one frame later.
//  5. Load accepted in cycle 23 (the boundary):
//     - Frame 1 keeps the old value; the new value appears from cycle 50.
//  6. Reset pulsed in cycle 15 (digit2 dwell) with a load pending:
//     - Next cycle: digit_sel=0, segments=7'h7F, load_ready=1.
//     - The scan restarts at digit0 and display reads 0000.

Source files
------------

// File: rtl/segment_scan_ctrl_if.sv
// Load port of the segment scan controller.
// A valid/ready handshake that carries one nibble per digit.
interface segment_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load_valid;
  logic                    load_ready;
  logic [4*NUM_DIGITS-1:0] load_value;

  modport master (
    output load_valid,
    output load_value,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_value,
    output load_ready
  );
endinterface

// File: rtl/segment_scan_ctrl.sv
// Scans one shared seven-segment driver across several digits.
// Display values are double-buffered and committed at frame boundaries.
module segment_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  Clock,
  input  logic                  Reset,
  segment_scan_ctrl_if.slave    load,
  input  logic [NUM_DIGITS-1:0] digit_enable,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic [6:0]            segments,
  output logic                  frame_done
);

  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ?
                        DWELL_CYCLES : BLANK_CYCLES;
  localparam int TW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [TW-1:0] T_DWELL = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] T_BLANK = TW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] I_LAST  = IW'(NUM_DIGITS - 1);

  typedef enum logic {
    BLANK,
    SHOW
  } state_t;

  state_t                  state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [DW-1:0]           display_q, display_d;
  logic [DW-1:0]           shadow_q, shadow_d;
  logic                    pending_q, pending_d;
  logic [NUM_DIGITS-1:0]   en_q;
  logic [3:0]              nib;
  logic                    lit;

  function automatic logic [6:0] seven_segment(
    input logic [3:0] v
  );
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= BLANK;
      timer_q   <= '0;
      idx_q     <= '0;
      display_q <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      en_q      <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      display_q <= display_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      en_q      <= digit_enable;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q + TW'(1);
    idx_d      = idx_q;
    display_d  = display_q;
    shadow_d   = shadow_q;
    pending_d  = pending_q;
    frame_done = 1'b0;
    unique case (state_q)
      BLANK: begin
        if (timer_q == T_BLANK) begin
          state_d = SHOW;
          timer_d = '0;
        end
      end
      SHOW: begin
        frame_done = (idx_q == I_LAST) &&
                     (timer_q == T_DWELL);
        if (timer_q == T_DWELL) begin
          state_d = BLANK;
          timer_d = '0;
          idx_d   = (idx_q == I_LAST) ?
                    '0 : idx_q + IW'(1);
        end
      end
    endcase
    // Commit needs pending=1 and accept needs pending=0,
    // so a boundary-cycle load waits for the next frame.
    if (frame_done && pending_q) begin
      display_d = shadow_q;
      pending_d = 1'b0;
    end
    if (load.load_valid && !pending_q) begin
      shadow_d  = load.load_value;
      pending_d = 1'b1;
    end
  end

  assign load.load_ready = !pending_q;

  always_comb begin
    nib = 4'h0;
    lit = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (IW'(k) == idx_q) begin
        nib = display_q[4*k +: 4];
        lit = en_q[k];
      end
    end
  end

  always_comb begin
    digit_sel = '0;
    segments  = 7'h7F;
    if (state_q == SHOW && lit) begin
      digit_sel = NUM_DIGITS'(1) << idx_q;
      segments  = seven_segment(nib);
    end
  end

endmodule

// File: tb/tb_segment_scan_ctrl.sv
// Bench for segment_scan_ctrl: directed steps plus random traffic,
// checked each cycle against a frame-arithmetic reference model.
module tb_segment_scan_ctrl;

  localparam int N     = 4;
  localparam int D     = 4;
  localparam int B     = 2;
  localparam int SLOT  = B + D;

  localparam logic [6:0] SEG_AH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] en;
  logic [N-1:0] sel;
  logic [6:0]   seg;
  logic         fd;

  segment_scan_ctrl_if #(.NUM_DIGITS(N)) lif ();

  segment_scan_ctrl #(
    .NUM_DIGITS  (N),
    .DWELL_CYCLES(D),
    .BLANK_CYCLES(B)
  ) dut (
    .Clock       (clk),
    .Reset       (rst),
    .load        (lif),
    .digit_enable(en),
    .digit_sel   (sel),
    .segments    (seg),
    .frame_done  (fd)
  );

  always #5 clk = ~clk;

  int           n_chk  = 0;
  int           n_fail = 0;
  int           c;
  logic         m_pend;
  logic [15:0]  m_shadow;
  logic [15:0]  m_disp;
  logic [N-1:0] m_en;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic         v,
                     input logic [15:0]  val,
                     input logic [N-1:0] e,
                     input logic         r);
    int         s, p;
    logic [N-1:0] es;
    logic [6:0] eg;
    logic       ef, commit, accept;
    logic [3:0] nb;
    @(negedge clk);
    s  = (c / SLOT) % N;
    p  = c % SLOT;
    nb = 4'(m_disp >> (4 * s));
    es = '0;
    eg = 7'h7F;
    if (p >= B && m_en[s]) begin
      es = N'(1) << s;
      eg = ~SEG_AH[nb];
    end
    ef = (s == N - 1) && (p == SLOT - 1);
    chk("digit_sel",  32'(sel), 32'(es));
    chk("segments",   32'(seg), 32'(eg));
    chk("frame_done", 32'(fd),  32'(ef));
    chk("load_ready", 32'(lif.load_ready), 32'(!m_pend));
    lif.load_valid = v;
    lif.load_value = val;
    en  = e;
    rst = r;
    @(posedge clk);
    commit = ef && m_pend;
    accept = v && !m_pend;
    m_en   = e;
    if (r) begin
      c = 0; m_pend = 1'b0; m_disp = '0; m_shadow = '0;
    end else begin
      if (commit) begin
        m_disp = m_shadow;
        m_pend = 1'b0;
      end
      if (accept) begin
        m_shadow = val;
        m_pend   = 1'b1;
      end
      c++;
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_sel",   32'(sel), 32'h0);
    chk("rst_seg",   32'(seg), 32'h7F);
    chk("rst_ready", 32'(lif.load_ready), 32'h1);
    chk("rst_fd",    32'(fd),  32'h0);
  endtask

  task automatic do_reset();
    cyc(1'b0, 16'h0, 4'hF, 1'b1);
    #1;
    chk_reset_state();
  endtask

  initial begin
    rst            = 1'b1;
    en             = 4'hF;
    lif.load_valid = 1'b0;
    lif.load_value = '0;
    m_en = 4'hF; m_pend = 1'b0; m_disp = '0; m_shadow = '0;
    repeat (2) @(posedge clk);
    c = 0;
    #1;
    chk_reset_state();

    // idle scan timing
    for (int i = 0; i < 30; i++) begin
      cyc(1'b0, 16'h0, 4'hF, 1'b0);
      #1;
      if (c == 2) begin
        chk("p1_d0_sel", 32'(sel), 32'h1);
        chk("p1_d0_seg", 32'(seg), 32'h40);
      end
      if (c == 23) chk("p1_fd", 32'(fd), 32'h1);
      if (c == 26) chk("p1_wrap", 32'(sel), 32'h1);
    end

    // single load in cycle 5
    do_reset();
    for (int i = 0; i < 50; i++) begin
      cyc(c == 5, 16'h1234, 4'hF, 1'b0);
      #1;
      if (c == 20) chk("p2_busy", 32'(lif.load_ready), 32'h0);
      if (c == 24) chk("p2_free", 32'(lif.load_ready), 32'h1);
      if (c == 26) chk("p2_d0_4", 32'(seg), 32'h19);
      if (c == 44) begin
        chk("p2_d3_sel", 32'(sel), 32'h8);
        chk("p2_d3_1",   32'(seg), 32'h79);
      end
    end

    // digit2 disabled
    do_reset();
    for (int i = 0; i < 30; i++) begin
      cyc(1'b0, 16'h0, 4'b1011, 1'b0);
      #1;
      if (c == 15) begin
        chk("p3_off_sel", 32'(sel), 32'h0);
        chk("p3_off_seg", 32'(seg), 32'h7F);
      end
      if (c == 21) chk("p3_d3_sel", 32'(sel), 32'h8);
      if (c == 23) chk("p3_fd", 32'(fd), 32'h1);
    end

    // valid held high, value changing every cycle
    do_reset();
    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, 16'($urandom), 4'hF, 1'b0);
      #1;
      if (c == 24) chk("p4_ready", 32'(lif.load_ready), 32'h1);
      if (c == 25) chk("p4_taken", 32'(lif.load_ready), 32'h0);
    end

    // load on the boundary cycle
    do_reset();
    for (int i = 0; i < 55; i++) begin
      cyc(c == 23, 16'hABCD, 4'hF, 1'b0);
      #1;
      if (c == 26) chk("p5_old", 32'(seg), 32'h40);
      if (c == 50) begin
        chk("p5_new_sel", 32'(sel), 32'h1);
        chk("p5_new_seg", 32'(seg), 32'h21);
      end
    end

    // reset mid-frame with a load pending
    do_reset();
    for (int i = 0; i < 16; i++)
      cyc(c == 5, 16'h5678, 4'hF, c == 15);
    #1;
    chk_reset_state();
    for (int i = 0; i < 30; i++) begin
      cyc(1'b0, 16'h0, 4'hF, 1'b0);
      #1;
      if (c == 2) chk("p6_zero", 32'(seg), 32'h40);
    end

    // random traffic
    begin
      logic [N-1:0] re;
      re = 4'hF;
      for (int i = 0; i < 1500; i++) begin
        if (i % 37 == 0) re = N'($urandom);
        cyc($urandom_range(3) == 0, 16'($urandom), re,
            $urandom_range(399) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
